sram_like_data_responder: RTL and testbench

Responder end of the CPU's sram-like data interface (req/addr_ok/data_ok). It accepts read and write requests from the EXE stage master, performs them on an internal word-addressed memory, and returns responses strictly in order after a fixed latency. Its configurable latency and bench-driven address backpressure let the pipeline's request/response handshake and its flush/waiting logic be tested against a simulation data memory.

---
 rtl/sram_like_data_responder.sv | 114 +++++++++++
 tb/tb_sram_like_data_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_data_responder.sv
// Responder side of the sram-like data interface: word-addressed memory with
// in-order responses returned a fixed DATA_LAT cycles after each address handshake.
module sram_like_data_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 4,
  parameter int DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_data_ok,
  input  logic        addr_block,
  output logic        busy
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int AW = $clog2(DATA_LAT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(DATA_LAT);
  // Age during the first cycle after the push is 0, so popping at DATA_LAT-2
  // puts the registered data_ok exactly DATA_LAT cycles after the handshake.
  localparam logic [AW-1:0] POP_AGE = AW'((DATA_LAT >= 2) ? DATA_LAT - 2 : 0);
  localparam bit BYPASS = (DATA_LAT == 1);

  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [RESP_DEPTH-1:0] valid;
  logic                  is_write_q [RESP_DEPTH];
  logic [31:0]           data_q     [RESP_DEPTH];
  logic [AW-1:0]         age_q      [RESP_DEPTH];
  logic                  handshake;
  logic                  push;
  logic                  pop;
  logic                  unused_ok;

  assign idx               = data_sram_addr[ADDR_WIDTH+1:2];
  assign rd_word           = mem[idx];
  assign data_sram_addr_ok = data_sram_req && !addr_block && (count < CW'(RESP_DEPTH));
  assign handshake         = data_sram_req && data_sram_addr_ok;
  assign push              = handshake && !BYPASS;
  assign pop               = !BYPASS && valid[rd_ptr] && (age_q[rd_ptr] == POP_AGE);
  assign busy              = (count != '0);
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset && handshake && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count             <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      valid             <= '0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
    end else begin
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
      if (pop) begin
        valid[rd_ptr]     <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
        data_sram_data_ok <= 1'b1;
        data_sram_rdata   <= is_write_q[rd_ptr] ? 32'h0 : data_q[rd_ptr];
      end else if (BYPASS && handshake) begin
        data_sram_data_ok <= 1'b1;
        data_sram_rdata   <= data_sram_wr ? 32'h0 : rd_word;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload and age need no reset; valid gates them and a push rewrites all three.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RESP_DEPTH; i++) begin
      if (push && wr_ptr == PW'(i)) begin
        is_write_q[i] <= data_sram_wr;
        data_q[i]     <= data_sram_wr ? 32'h0 : rd_word;
        age_q[i]      <= '0;
      end else if (valid[i] && age_q[i] != AGE_MAX) begin
        age_q[i] <= age_q[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_pop_nonempty: assert (!(pop && count == '0));
      a_count_bound:  assert (count <= CW'(RESP_DEPTH));
    end
  end
endmodule

// File: tb/tb_sram_like_data_responder.sv
// Bench: two responders (DATA_LAT 2 and 8) on shared inputs, checked every cycle
// against a response-list model plus directed literal expectations.
module tb_sram_like_data_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic        block;
  logic [1:0]  aok;
  logic [1:0]  dok;
  logic [1:0]  bsy;
  logic [31:0] rdv [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sram_like_data_responder #(.ADDR_WIDTH(10), .RESP_DEPTH(4), .DATA_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(strb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]), .data_sram_rdata(rdv[0]),
    .data_sram_data_ok(dok[0]), .addr_block(block), .busy(bsy[0]));

  sram_like_data_responder #(.ADDR_WIDTH(10), .RESP_DEPTH(4), .DATA_LAT(8)) u_lat8 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(strb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]), .data_sram_rdata(rdv[1]),
    .data_sram_data_ok(dok[1]), .addr_block(block), .busy(bsy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: every accepted request becomes a response due at hs_cycle+latency.
  typedef struct {
    int          d;
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] mm [2][1024];
  bit          armed = 0;
  bit          hs_now [2];
  logic [31:0] last_rd [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 8;
  endfunction

  always @(negedge clk) begin
    int          cnt;
    bit          edok;
    bit          eok;
    logic [31:0] erd;
    int          ix;
    resp_t       r;
    for (int d = 0; d < 2; d++) begin
      cnt  = 0;
      edok = 0;
      erd  = 0;
      foreach (pend[i]) begin
        if (pend[i].d == d) begin
          if (pend[i].due > cyc) cnt++;
          if (pend[i].due == cyc) begin
            edok = 1;
            erd  = pend[i].data;
          end
        end
      end
      eok = req && !block && (cnt < 4);
      if (armed) begin
        chk($sformatf("addr_ok[%0d]", d), {31'b0, aok[d]}, {31'b0, eok});
        chk($sformatf("data_ok[%0d]", d), {31'b0, dok[d]}, {31'b0, edok});
        chk($sformatf("rdata[%0d]", d), rdv[d], erd);
        chk($sformatf("busy[%0d]", d), {31'b0, bsy[d]}, {31'b0, cnt != 0});
      end
      if (dok[d]) last_rd[d] = rdv[d];
      hs_now[d] = !reset && req && eok;
      if (hs_now[d]) begin
        ix = int'(addr[11:2]);
        r.d   = d;
        r.due = cyc + lat_of(d);
        r.data = 32'h0;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) mm[d][ix][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          r.data = mm[d][ix];
        end
        pend.push_back(r);
      end
    end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].due <= cyc) pend.delete(i);
    if (reset) begin
      pend.delete();
      armed = 1;
    end
  end

  task automatic drive(input logic rq, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    req = rq; wr = w; size = sz; addr = a; strb = st; wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int n);
    idle();
    repeat (n) tick();
  endtask

  // Holds the request until responder `sel` takes it; entered and left at posedge+1.
  task automatic issue(input int sel, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    drive(1'b1, w, sz, a, st, wd);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (hs_now[sel]) begin
        idle();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout actual=no_handshake required=handshake sel=%0d addr=%h", sel, a);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          j;
    bit          e;
    logic [31:0] ex;
    reset = 1'b1;
    block = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy0", {31'b0, bsy[0]}, 32'd0);
    chk("reset_data_ok1", {31'b0, dok[1]}, 32'd0);
    chk("reset_rdata0", rdv[0], 32'h0);
    tick();

    for (int i = 0; i < 16; i++)
      issue(1, 1'b1, 2'd2, 32'h200 + 32'(4 * i), 4'hF, 32'hA500_0000 | 32'(i));
    wait_idle(12);

    // write then read back-to-back
    drive(1'b1, 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk); chk("t1_aok_wr", {31'b0, aok[0]}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    @(negedge clk); chk("t1_aok_rd", {31'b0, aok[0]}, 32'd1);
    tick();
    idle();
    @(negedge clk); chk("t1_dok_wr", {31'b0, dok[0]}, 32'd1); chk("t1_rd_wr", rdv[0], 32'h0);
    tick();
    @(negedge clk); chk("t1_dok_rd", {31'b0, dok[0]}, 32'd1); chk("t1_rd_rd", rdv[0], 32'hDEAD_BEEF);
    tick();
    @(negedge clk); chk("t1_busy_T4", {31'b0, bsy[0]}, 32'd0);
    tick();
    wait_idle(12);

    // partial writes, size independence, zero-strobe write
    issue(1, 1'b1, 2'd2, 32'h20, 4'hF, 32'h1122_3344);
    issue(1, 1'b1, 2'd2, 32'h20, 4'b0100, 32'h00AA_0000);
    issue(1, 1'b1, 2'd0, 32'h20, 4'b0001, 32'h0000_00BB);
    issue(0, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
    wait_idle(12);
    chk("t2_merge", last_rd[0], 32'h11AA_33BB);
    issue(1, 1'b1, 2'd2, 32'h24, 4'hF, 32'h0);
    issue(1, 1'b1, 2'd2, 32'h28, 4'hF, 32'h0);
    issue(1, 1'b1, 2'd0, 32'h24, 4'b0010, 32'h0000_CD00);
    issue(1, 1'b1, 2'd2, 32'h28, 4'b0010, 32'h0000_CD00);
    issue(1, 1'b1, 2'd2, 32'h28, 4'b0000, 32'hFFFF_FFFF);
    issue(0, 1'b0, 2'd2, 32'h24, 4'h0, 32'h0);
    wait_idle(12);
    chk("t2_byte_size", last_rd[0], 32'h0000_CD00);
    issue(0, 1'b0, 2'd2, 32'h28, 4'h0, 32'h0);
    wait_idle(12);
    chk("t2_word_size_zero_strb", last_rd[0], 32'h0000_CD00);

    // streaming reads at DATA_LAT=2
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 2'd2, 32'h200 + 32'(4 * k), 4'h0, 32'h0);
      else idle();
      @(negedge clk);
      if (k < 8) chk("t3_aok", {31'b0, aok[0]}, 32'd1);
      e  = (k >= 2 && k <= 9);
      ex = e ? (32'hA500_0000 | 32'(k - 2)) : 32'h0;
      chk("t3_dok", {31'b0, dok[0]}, {31'b0, e});
      chk("t3_rdata", rdv[0], ex);
      tick();
    end
    wait_idle(12);

    // backpressure, then fill the DATA_LAT=8 queue
    block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'd2, 32'h200, 4'h0, 32'h0);
      @(negedge clk);
      chk("t4_block_aok", {31'b0, aok[0]}, 32'd0);
      chk("t4_block_busy", {31'b0, bsy[1]}, 32'd0);
      tick();
    end
    block = 1'b0;
    j = 0;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 2'd2, 32'h200 + 32'(4 * j), 4'h0, 32'h0);
      @(negedge clk);
      e = (k < 4) || (k == 8);
      chk("t4_full_aok", {31'b0, aok[1]}, {31'b0, e});
      chk("t4_first_dok", {31'b0, dok[1]}, {31'b0, k == 8});
      tick();
      if (e) j++;
    end
    wait_idle(14);

    // reset with DATA_LAT=8 responses in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'd2, 32'h200 + 32'(4 * k), 4'h0, 32'h0);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_no_dok8", {31'b0, dok[1]}, 32'd0);
      chk("t5_no_dok2", {31'b0, dok[0]}, 32'd0);
      chk("t5_busy8", {31'b0, bsy[1]}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 2'd2, 32'h20C, 4'h0, 32'h0);
    @(negedge clk); chk("t5_aok", {31'b0, aok[1]}, 32'd1);
    tick();
    idle();
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      chk("t5_dok_lat", {31'b0, dok[1]}, {31'b0, m == 8});
      if (m == 8) chk("t5_rdata", rdv[1], 32'hA500_0003);
      tick();
    end
    wait_idle(12);

    // address aliasing
    issue(1, 1'b1, 2'd2, 32'h0000_1004, 4'hF, 32'h600D_F00D);
    issue(0, 1'b0, 2'd2, 32'hFFFF_F007, 4'h0, 32'h0);
    wait_idle(12);
    chk("t6_alias", last_rd[0], 32'h600D_F00D);

    // randomized traffic over 16 words, with aliasing bits, blocking and rare resets
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      block = ($urandom_range(0, 4) == 0);
      drive(!reset && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)),
            ($urandom() & 32'hFFFF_F003) | (32'h200 + 32'(4 * $urandom_range(0, 15))),
            4'($urandom_range(0, 15)), $urandom());
      tick();
    end
    reset = 1'b0;
    block = 1'b0;
    wait_idle(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
